dreq_arb_rr_n: RTL and testbench
================================

# dreq_arb_rr_n

Parametrised N:1 round-robin arbiter for `dreq_t` request streams, with a registered output and an optional burst-hold mode. It merges per-channel descriptor request queues into one `metaIntf` towards the shared DMA/host request path. Every output is reset to a defined value, and the winner index travels alongside the data. It supersedes fixed 2:1 arbitration wherever more than two request sources share one `dreq_t` sink.

## Interface
Parameters:
- `N_PORTS`, 4, number of inputs; legal range 2..16.
- `BURST_LEN`, 1, maximum consecutive transfers granted to one winner; legal range 1..16; a value of 1 gives pure round-robin.
- `CNT_BITS`, 32, width of each statistics counter; used only with `DREQ_ARB_STATS_EN`.

Ports:
- `aclk`  in  1  the single clock; all logic is on its rising edge.
- `areset`  in  1  reset; **synchronous, active-high**.
- `s_req[N_PORTS]`  metaIntf.s  `$bits(dreq_t)`  input request streams, `STYPE=dreq_t`.
- `m_req`  metaIntf.m  `$bits(dreq_t)`  merged output stream.
- `m_id`  out  `ID_BITS=max(1,$clog2(N_PORTS))`  source port of the current `m_req` beat; changes together with `m_req.data`.
- `stat_clr`  in  1  clears all statistics counters (stats build only).
- `stat_cnt`  out  `N_PORTS*CNT_BITS`  accepted-request count per port; port i occupies bits [i*CNT_BITS +: CNT_BITS] (stats build only).

## Operation
- State: `ptr` (ID_BITS), FSM {ARB, HOLD}, `owner` (ID_BITS), `bcnt` (4 bits).
- **ARB**
  - Winner is the first port with valid=1, scanning `ptr`, `ptr+1`, … modulo N_PORTS.
  - No valid port: no grant is made.
  - On a handshake (`s_req[w].valid & ready`):
    - If BURST_LEN==1: `ptr <= w+1 mod N_PORTS`; the FSM stays in ARB.
    - Otherwise: `owner <= w`, `bcnt <= 1`, go to HOLD.
- **HOLD**
  - Only `owner` is eligible.
  - On a handshake: `bcnt++`. When the new `bcnt` equals BURST_LEN: `ptr <= owner+1 mod N_PORTS`, go to ARB.
  - If `owner` valid=0 in a cycle: no grant that cycle; `ptr <= owner+1 mod N_PORTS`, go to ARB. This costs one bubble cycle.
- Ready routing: `s_req[i].ready = (i==winner) & int_ready`. Every other ready is 0.
- Data is never dropped or duplicated. `m_req` beats preserve per-port order.
- Wrap: `ptr` at N_PORTS-1 followed by a grant goes to 0. Non-power-of-2 N_PORTS wraps at N_PORTS-1, not at 2^ID_BITS-1.
- Reset:
  - Takes effect on any cycle, including mid-burst and while the output register is full.
  - Pending data is flushed.
  - Afterwards `ptr=0`, `owner=0`, `bcnt=0`, FSM=ARB.
  - `m_req.valid=0`, `m_req.data=0`, `m_id=0`.
  - `stat_cnt=0`; all `s_req[i].ready=0` during reset.

## Timing
- Output register: full-throughput, one entry.
  - `int_ready = !out_valid | m_req.ready`.
  - Sustains 1 beat/cycle when `m_req.ready` is held high.
- Latency: an input handshake in cycle t makes `m_req.valid=1` in t+1, with the data and `m_id` of that beat.
- `m_req.valid`, `m_req.data` and `m_id` are stable while valid=1 and ready=0.
- Inputs must keep data stable while valid=1 and ready=0. The arbiter may withdraw ready; an input must not withdraw valid.
- Combinational paths: `m_req.ready` → `s_req[*].ready`. There is no input-valid → output-valid path.

## Configuration
- `DREQ_ARB_STATS_EN` defined:
  - Per-port counters increment on each accepted input handshake and saturate at all-ones.
  - `stat_clr` clears them synchronously. Clear has priority over a same-cycle increment; the result is 0.
  - Counters are registered; the count is visible the cycle after the handshake.
- Not defined:
  - `stat_cnt` is tied to 0 and `stat_clr` is ignored.
  - No counter logic is generated.

## Structure
- `dreq_t` stays in `lynxTypes`.
- Add `DREQ_ARB_MAX_PORTS=16` and `DREQ_ARB_MAX_BURST=16` to `lynxTypes` for parameter checks.
- The output stage is the existing sub-module `meta_reg`, instanced with `DATA_BITS=$bits(dreq_t)+ID_BITS`. `m_id` is carried in the upper bits of that register.
- The winner-select scan is a local function in the module, not a separate sub-module.

## Test plan
- **Fair rotation:** N_PORTS=4, BURST_LEN=1, all ports valid continuously, `m_req.ready=1`, 8 beats → `m_id` sequence is 0,1,2,3,0,1,2,3 with no bubble; the first beat appears the cycle after the first handshake.
- **Skip idle ports:** N_PORTS=4, only ports 1 and 3 valid, `ptr=0` → `m_id` 1,3,1,3; ports 0 and 2 see ready=0 throughout.
- **Burst hold:** N_PORTS=3, BURST_LEN=4, all valid → `m_id` 0,0,0,0,1,1,1,1,2,2,2,2. Port 1 deasserts valid after 2 beats of its burst → one bubble, then port 2 is granted.
- **Backpressure:** `m_req.ready=0` for 5 cycles with beat A held → `m_req.data`/`m_id` stay stable and every `s_req.ready=0`. Releasing ready delivers A, then B on the next cycle.
- **Reset mid-burst:** assert `areset` during HOLD with owner=2 and the output full → next cycle `m_req.valid=0`, `m_id=0`. The first grant after reset goes to port 0 when all ports are valid.
- **Stats (`DREQ_ARB_STATS_EN`):** 10 beats from port 0, then `stat_clr` in the same cycle as a port-0 handshake → `stat_cnt[0]` reads 10 before the clear and 0 after it. Preload CNT_BITS=4 to 15 and apply one more beat → it stays at 15.

Source files
------------

// File: rtl/dreq_arb_rr_n_pkg.sv
// dreq_arb_rr_n_pkg: request descriptor type, FSM encoding and parameter limits
// shared by the round-robin dreq_t arbiter and its stream interface.
package dreq_arb_rr_n_pkg;

   // Upper bounds used for elaboration-time parameter checks
   localparam int DREQ_ARB_MAX_PORTS = 16;
   localparam int DREQ_ARB_MAX_BURST = 16;

   // Host/DMA descriptor request (86 bits)
   typedef struct packed {
      logic [1:0]  strm;
      logic [3:0]  vfid;
      logic [3:0]  dest;
      logic [27:0] len;
      logic [47:0] vaddr;
   } dreq_t;

   // Arbitration FSM: open round-robin scan or burst hold on one owner
   typedef enum logic [0:0] {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   // Width of a port index, never less than one bit
   function automatic int id_bits(input int n_ports);
      return (n_ports > 1) ? $clog2(n_ports) : 1;
   endfunction

endpackage

// File: rtl/dreq_arb_rr_n_if.sv
// metaIntf: valid/ready stream carrying one STYPE beat per transfer.
// Modport m drives a stream, modport s receives one.
interface metaIntf
   import dreq_arb_rr_n_pkg::*;
#(
   parameter type STYPE = dreq_t
) ();

   logic valid;
   logic ready;
   STYPE data;

   modport m (output valid, output data, input ready);
   modport s (input valid, input data, output ready);

endinterface

// File: rtl/dreq_arb_rr_n_meta_reg.sv
// meta_reg: one-entry, full-throughput output register. It refills in the
// same cycle it drains, so a continuously ready sink sees one beat per cycle.
module meta_reg #(
   parameter int DATA_BITS = 8
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data
);

   logic                 valid_r;
   logic [DATA_BITS-1:0] data_r;

   assign in_ready  = ~valid_r | out_ready;
   assign out_valid = valid_r;
   assign out_data  = data_r;

   // Load on accept, empty once drained, flush on reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         valid_r <= 1'b0;
         data_r  <= {DATA_BITS{1'b0}};
      end else if (in_valid && in_ready) begin
         valid_r <= 1'b1;
         data_r  <= in_data;
      end else if (out_ready) begin
         valid_r <= 1'b0;
         data_r  <= data_r;
      end else begin
         valid_r <= valid_r;
         data_r  <= data_r;
      end
   end

endmodule

// File: rtl/dreq_arb_rr_n.sv
// dreq_arb_rr_n: N:1 round-robin arbiter for dreq_t request streams with an
// optional burst hold (BURST_LEN > 1) and a registered output carrying the
// winner index in m_id. Per-port saturating statistics counters are built
// only when DREQ_ARB_STATS_EN is defined; otherwise stat_cnt is tied to 0.
module dreq_arb_rr_n
   import dreq_arb_rr_n_pkg::*;
#(
   parameter int N_PORTS   = 4,
   parameter int BURST_LEN = 1,
   parameter int CNT_BITS  = 32,
   localparam int ID_BITS  = id_bits(N_PORTS)
) (
   input  logic                         aclk,
   input  logic                         areset,
   metaIntf.s                           s_req [N_PORTS],
   metaIntf.m                           m_req,
   output logic [ID_BITS-1:0]           m_id,
   input  logic                         stat_clr,
   output logic [N_PORTS*CNT_BITS-1:0]  stat_cnt
);

   localparam int DREQ_BITS = $bits(dreq_t);
   localparam int REG_BITS  = DREQ_BITS + ID_BITS;
   localparam logic [ID_BITS-1:0] LAST_ID   = ID_BITS'(N_PORTS - 1);
   localparam logic [4:0]         BURST_END = 5'(BURST_LEN);

   if (N_PORTS < 2 || N_PORTS > DREQ_ARB_MAX_PORTS) begin : g_bad_ports
      $error("dreq_arb_rr_n: N_PORTS out of range 2..16");
   end
   if (BURST_LEN < 1 || BURST_LEN > DREQ_ARB_MAX_BURST) begin : g_bad_burst
      $error("dreq_arb_rr_n: BURST_LEN out of range 1..16");
   end

   logic [N_PORTS-1:0]  req_valid_s;
   logic [N_PORTS-1:0]  req_ready_s;
   dreq_t               req_data_s [N_PORTS];

   arb_state_e          state_r, state_n;
   logic [ID_BITS-1:0]  ptr_r, ptr_n;
   logic [ID_BITS-1:0]  owner_r, owner_n;
   logic [3:0]          bcnt_r, bcnt_n;
   logic [4:0]          bcnt_inc_s;
   logic [ID_BITS:0]    scan_s;
   logic [ID_BITS-1:0]  winner_s;
   logic                grant_s;
   logic                int_ready_s;
   logic                out_valid_s;
   logic [REG_BITS-1:0] out_data_s;

   // Flatten the interface array so the scan can index it dynamically
   for (genvar g = 0; g < N_PORTS; g++) begin : g_port
      assign req_valid_s[g]  = s_req[g].valid;
      assign req_data_s[g]   = s_req[g].data;
      assign s_req[g].ready  = req_ready_s[g];
   end

   // Next port index, wrapping at N_PORTS-1 rather than at 2^ID_BITS-1
   function automatic logic [ID_BITS-1:0] next_id(input logic [ID_BITS-1:0] id);
      return (id == LAST_ID) ? {ID_BITS{1'b0}} : id + ID_BITS'(1);
   endfunction

   // First valid port from start upward modulo N_PORTS; returns {found, index}
   function automatic logic [ID_BITS:0] rr_scan(input logic [N_PORTS-1:0] vld,
                                                input logic [ID_BITS-1:0] start);
      logic [ID_BITS-1:0] idx;
      logic [ID_BITS-1:0] pick;
      logic               found;
      idx   = start;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
         pick  = (!found && vld[idx]) ? idx : pick;
         found = found | vld[idx];
         idx   = next_id(idx);
      end
      return {found, pick};
   endfunction

   // Winner select, ready routing and ARB/HOLD next-state decode
   always_comb begin
      state_n    = state_r;
      ptr_n      = ptr_r;
      owner_n    = owner_r;
      bcnt_n     = bcnt_r;
      scan_s     = rr_scan(req_valid_s, ptr_r);
      winner_s   = scan_s[ID_BITS-1:0];
      grant_s    = scan_s[ID_BITS];
      bcnt_inc_s = {1'b0, bcnt_r} + 5'd1;
      case (state_r)
         ARB: begin
            if (grant_s && int_ready_s) begin
               if (BURST_LEN == 1) begin
                  ptr_n = next_id(winner_s);
               end else begin
                  owner_n = winner_s;
                  bcnt_n  = 4'd1;
                  state_n = HOLD;
               end
            end else begin
               state_n = ARB;
            end
         end
         HOLD: begin
            winner_s = owner_r;
            grant_s  = req_valid_s[owner_r];
            if (!grant_s) begin
               // owner went idle: give up the burst, costing one bubble
               ptr_n   = next_id(owner_r);
               state_n = ARB;
            end else if (int_ready_s) begin
               bcnt_n = bcnt_inc_s[3:0];
               if (bcnt_inc_s == BURST_END) begin
                  ptr_n   = next_id(owner_r);
                  state_n = ARB;
               end else begin
                  state_n = HOLD;
               end
            end else begin
               state_n = HOLD;
            end
         end
         default: begin
            state_n = ARB;
         end
      endcase
      req_ready_s = {N_PORTS{1'b0}};
      for (int i = 0; i < N_PORTS; i++) begin
         req_ready_s[i] = grant_s & int_ready_s & ~areset & (winner_s == ID_BITS'(i));
      end
   end

   // Arbitration state register
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r <= ARB;
         ptr_r   <= {ID_BITS{1'b0}};
         owner_r <= {ID_BITS{1'b0}};
         bcnt_r  <= 4'd0;
      end else begin
         state_r <= state_n;
         ptr_r   <= ptr_n;
         owner_r <= owner_n;
         bcnt_r  <= bcnt_n;
      end
   end

   // Output stage; the winner index rides in the upper bits with the beat
   meta_reg #(
      .DATA_BITS (REG_BITS)
   ) u_out_reg (
      .aclk      (aclk),
      .areset    (areset),
      .in_valid  (grant_s & ~areset),
      .in_ready  (int_ready_s),
      .in_data   ({winner_s, req_data_s[winner_s]}),
      .out_valid (out_valid_s),
      .out_ready (m_req.ready),
      .out_data  (out_data_s)
   );

   assign m_req.valid = out_valid_s;
   assign m_req.data  = out_data_s[DREQ_BITS-1:0];
   assign m_id        = out_data_s[REG_BITS-1 -: ID_BITS];

`ifdef DREQ_ARB_STATS_EN
   for (genvar g = 0; g < N_PORTS; g++) begin : g_stat
      logic [CNT_BITS-1:0] cnt_r;
      // Saturating accepted-request counter; clear wins over increment
      always_ff @(posedge aclk) begin
         if (areset || stat_clr) begin
            cnt_r <= {CNT_BITS{1'b0}};
         end else if (req_valid_s[g] && req_ready_s[g] && (cnt_r != {CNT_BITS{1'b1}})) begin
            cnt_r <= cnt_r + CNT_BITS'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
      assign stat_cnt[g*CNT_BITS +: CNT_BITS] = cnt_r;
   end
`else
   logic unused_stat_clr_s;
   assign unused_stat_clr_s = stat_clr;
   assign stat_cnt          = {(N_PORTS*CNT_BITS){1'b0}};
`endif

endmodule

// File: tb/tb_dreq_arb_rr_n.sv
// tb_dreq_arb_rr_n: scoreboard bench for dreq_arb_rr_n. dut_a is a 4-port pure
// round-robin build, dut_b a 3-port build with BURST_LEN=4. Each source port
// emits a deterministic numbered sequence; expected {id, beat} pairs are queued
// when stimulus is set up and compared as the outputs deliver beats.
module tb_dreq_arb_rr_n;
   import dreq_arb_rr_n_pkg::*;

   localparam int NA = 4;
   localparam int NB = 3;
   localparam int CW = 4;

   typedef struct packed {
      logic [3:0] id;
      dreq_t      d;
   } beat_t;

   logic aclk = 1'b0;
   logic areset;
   logic stat_clr;
   always #5 aclk = ~aclk;

   metaIntf #(.STYPE(dreq_t)) a_s [NA] ();
   metaIntf #(.STYPE(dreq_t)) a_m ();
   metaIntf #(.STYPE(dreq_t)) b_s [NB] ();
   metaIntf #(.STYPE(dreq_t)) b_m ();

   logic [NA-1:0]    a_vld, a_rdy;
   logic [NB-1:0]    b_vld, b_rdy;
   dreq_t            a_dat [NA];
   dreq_t            b_dat [NB];
   logic             a_mrdy, b_mrdy;
   logic [1:0]       a_id, b_id;
   logic [NA*CW-1:0] a_stat;
   logic [NB*CW-1:0] b_stat;

   for (genvar g = 0; g < NA; g++) begin : g_a
      assign a_s[g].valid = a_vld[g];
      assign a_s[g].data  = a_dat[g];
      assign a_rdy[g]     = a_s[g].ready;
   end
   for (genvar g = 0; g < NB; g++) begin : g_b
      assign b_s[g].valid = b_vld[g];
      assign b_s[g].data  = b_dat[g];
      assign b_rdy[g]     = b_s[g].ready;
   end
   assign a_m.ready = a_mrdy;
   assign b_m.ready = b_mrdy;

   dreq_arb_rr_n #(.N_PORTS(NA), .BURST_LEN(1), .CNT_BITS(CW)) dut_a (
      .aclk(aclk), .areset(areset), .s_req(a_s), .m_req(a_m),
      .m_id(a_id), .stat_clr(stat_clr), .stat_cnt(a_stat));

   dreq_arb_rr_n #(.N_PORTS(NB), .BURST_LEN(4), .CNT_BITS(CW)) dut_b (
      .aclk(aclk), .areset(areset), .s_req(b_s), .m_req(b_m),
      .m_id(b_id), .stat_clr(stat_clr), .stat_cnt(b_stat));

   int    n_chk = 0;
   int    n_err = 0;
   int    a_rem [NA], a_seq [NA], a_pseq [NA];
   int    b_rem [NB], b_seq [NB], b_pseq [NB];
   int    a_pops = 0, b_pops = 0;
   int    base;
   logic  idle_rdy;
   beat_t qa [$];
   beat_t qb [$];

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic dreq_t mk(input int dut, input int p, input int k);
      dreq_t d;
      d.strm  = 2'(k);
      d.vfid  = 4'(p);
      d.dest  = 4'(dut);
      d.len   = 28'(k * 7 + p + 1);
      d.vaddr = {8'(dut), 8'(p), 32'(k)};
      return d;
   endfunction

   task automatic push_a(input int p);
      qa.push_back({4'(p), mk(0, p, a_pseq[p])});
      a_pseq[p]++;
   endtask

   task automatic push_b(input int p);
      qb.push_back({4'(p), mk(1, p, b_pseq[p])});
      b_pseq[p]++;
   endtask

   task automatic drive_src();
      for (int p = 0; p < NA; p++) begin
         a_vld[p] = (a_rem[p] > 0);
         a_dat[p] = mk(0, p, a_seq[p]);
      end
      for (int p = 0; p < NB; p++) begin
         b_vld[p] = (b_rem[p] > 0);
         b_dat[p] = mk(1, p, b_seq[p]);
      end
   endtask

   // One clock: score delivered beats, then advance sources that handshook
   task automatic tick();
      logic [NA-1:0] ha;
      logic [NB-1:0] hb;
      beat_t e;
      #1;
      if (a_m.valid && a_mrdy) begin
         check_val("a_beat_expected", 128'(qa.size() != 0), 128'd1);
         if (qa.size() != 0) begin
            e = qa.pop_front();
            check_val("a_id", 128'(a_id), 128'(e.id));
            check_val("a_data", 128'(a_m.data), 128'(e.d));
            a_pops++;
         end
      end
      if (b_m.valid && b_mrdy) begin
         check_val("b_beat_expected", 128'(qb.size() != 0), 128'd1);
         if (qb.size() != 0) begin
            e = qb.pop_front();
            check_val("b_id", 128'(b_id), 128'(e.id));
            check_val("b_data", 128'(b_m.data), 128'(e.d));
            b_pops++;
         end
      end
      ha = a_vld & a_rdy;
      hb = b_vld & b_rdy;
      @(posedge aclk);
      #1;
      for (int p = 0; p < NA; p++) if (ha[p]) begin a_rem[p]--; a_seq[p]++; end
      for (int p = 0; p < NB; p++) if (hb[p]) begin b_rem[p]--; b_seq[p]++; end
      drive_src();
      #1;
   endtask

   initial begin
      areset   = 1'b1;
      stat_clr = 1'b0;
      a_mrdy   = 1'b1;
      b_mrdy   = 1'b1;
      for (int p = 0; p < NA; p++) begin a_rem[p] = 1; a_seq[p] = 0; a_pseq[p] = 0; end
      for (int p = 0; p < NB; p++) begin b_rem[p] = 1; b_seq[p] = 0; b_pseq[p] = 0; end
      drive_src();
      repeat (3) tick();

      // Reset state, with every source presenting valid
      check_val("rst_a_valid", 128'(a_m.valid), 128'd0);
      check_val("rst_a_id",    128'(a_id),      128'd0);
      check_val("rst_a_data",  128'(a_m.data),  128'd0);
      check_val("rst_a_ready", 128'(a_rdy),     128'd0);
      check_val("rst_b_valid", 128'(b_m.valid), 128'd0);
      check_val("rst_b_ready", 128'(b_rdy),     128'd0);
      for (int p = 0; p < NA; p++) a_rem[p] = 0;
      for (int p = 0; p < NB; p++) b_rem[p] = 0;
      drive_src();
      areset = 1'b0;
      tick();

      // Fair rotation: 8 beats in 9 cycles, ids 0,1,2,3,0,1,2,3
      for (int p = 0; p < NA; p++) a_rem[p] = 2;
      for (int i = 0; i < 8; i++) push_a(i % NA);
      drive_src();
      base = a_pops;
      repeat (9) tick();
      check_val("fair_beats_in_window", 128'(a_pops - base), 128'd8);
      repeat (2) tick();
      check_val("fair_drain", 128'(qa.size()), 128'd0);

      // Skip idle ports: only 1 and 3 valid
      a_rem[1] = 2;
      a_rem[3] = 2;
      push_a(1); push_a(3); push_a(1); push_a(3);
      drive_src();
      base     = a_pops;
      idle_rdy = 1'b0;
      repeat (5) begin
         idle_rdy = idle_rdy | a_rdy[0] | a_rdy[2];
         tick();
      end
      check_val("skip_idle_ready", 128'(idle_rdy), 128'd0);
      check_val("skip_beats", 128'(a_pops - base), 128'd4);

      // Burst hold on the 3-port build: 0x4, 1x4, 2x4
      for (int p = 0; p < NB; p++) b_rem[p] = 4;
      for (int p = 0; p < NB; p++) for (int i = 0; i < 4; i++) push_b(p);
      drive_src();
      base = b_pops;
      repeat (13) tick();
      check_val("burst_beats", 128'(b_pops - base), 128'd12);

      // Owner 1 goes idle after 2 beats: one bubble, then port 2, then port 0
      b_rem[0] = 8; b_rem[1] = 2; b_rem[2] = 4;
      for (int i = 0; i < 4; i++) push_b(0);
      for (int i = 0; i < 2; i++) push_b(1);
      for (int i = 0; i < 4; i++) push_b(2);
      for (int i = 0; i < 4; i++) push_b(0);
      drive_src();
      base = b_pops;
      repeat (15) tick();
      check_val("bubble_beats", 128'(b_pops - base), 128'd13);
      repeat (3) tick();
      check_val("bubble_drain", 128'(qb.size()), 128'd0);

      // Backpressure: beat A held for 5 cycles, then A and B back to back
      a_rem[0] = 2;
      push_a(0); push_a(0);
      a_mrdy = 1'b0;
      drive_src();
      tick();
      repeat (5) begin
         check_val("bp_valid", 128'(a_m.valid), 128'd1);
         check_val("bp_id",    128'(a_id),      128'd0);
         check_val("bp_data",  128'(a_m.data),  128'(qa[0].d));
         check_val("bp_ready", 128'(a_rdy),     128'd0);
         tick();
      end
      a_mrdy = 1'b1;
      base = a_pops;
      repeat (2) tick();
      check_val("bp_release_beats", 128'(a_pops - base), 128'd2);

      // Reset mid-burst: owner 2 in HOLD with the output register full
      b_mrdy   = 1'b0;
      b_rem[2] = 8;
      drive_src();
      tick();
      check_val("rmb_pre_valid", 128'(b_m.valid), 128'd1);
      check_val("rmb_pre_id",    128'(b_id),      128'd2);
      areset = 1'b1;
      tick();
      check_val("rmb_valid", 128'(b_m.valid), 128'd0);
      check_val("rmb_id",    128'(b_id),      128'd0);
      check_val("rmb_data",  128'(b_m.data),  128'd0);
      check_val("rmb_ready", 128'(b_rdy),     128'd0);
      b_rem[0] = 1; b_rem[1] = 1; b_rem[2] = 0;
      push_b(0); push_b(1);
      drive_src();
      b_mrdy = 1'b1;
      areset = 1'b0;
      base = b_pops;
      repeat (6) tick();
      check_val("rmb_after_beats", 128'(b_pops - base), 128'd2);
      check_val("rmb_drain", 128'(qb.size()), 128'd0);

`ifdef DREQ_ARB_STATS_EN
      // Statistics: 10 beats, clear racing a handshake, then saturation
      a_rem[0] = 10;
      for (int i = 0; i < 10; i++) push_a(0);
      drive_src();
      repeat (12) tick();
      check_val("stat_ten", 128'(a_stat[CW-1:0]), 128'd10);
      a_rem[0] = 1;
      push_a(0);
      drive_src();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check_val("stat_clr_wins", 128'(a_stat[CW-1:0]), 128'd0);
      repeat (2) tick();
      a_rem[0] = 17;
      for (int i = 0; i < 17; i++) push_a(0);
      drive_src();
      repeat (19) tick();
      check_val("stat_saturate", 128'(a_stat[CW-1:0]), 128'd15);
      a_rem[0] = 1;
      push_a(0);
      drive_src();
      repeat (3) tick();
      check_val("stat_hold_max", 128'(a_stat[CW-1:0]), 128'd15);
`else
      check_val("stat_a_tied", 128'(a_stat), 128'd0);
      check_val("stat_b_tied", 128'(b_stat), 128'd0);
`endif
      repeat (2) tick();
      check_val("final_a_drain", 128'(qa.size()), 128'd0);
      check_val("final_b_drain", 128'(qb.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
